game_progress: RTL and testbench
================================

Name: game_progress

Overview:
- Game-progress controller feeding the VGA overlay stage.
- Turns a start key, a level select and judged hit/miss pulses into the overlay's status signals: stop, level, clk_blink, beat_cnt, star_cnt.
- Owns the beat timebase, a per-section miss tally, star award logic, and the idle/play/done state machine.
- Sits between the note-judging logic (upstream) and the VGA pixel mux (downstream).

Parameters:
- BEAT_DIV, 25_000_000, clk cycles per beat (0.25 s at 100 MHz).
- BLINK_DIV, 50_000_000, clk cycles per clk_blink half-period.
- MISS_LIMIT, 4, a section earns a star when its miss count is strictly below this.
- LAST_BEAT, 95, final beat index; sections end at 32, 64 and LAST_BEAT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse, "any button pressed".
- level_sel  in  2  requested level; 0 = none (start is ignored).
- hit  in  1  single-cycle pulse, correct note.
- miss  in  1  single-cycle pulse, wrong or missed note.
- stop  out  1  1 when not playing (IDLE or DONE).
- level  out  2  level latched at game start; 0 in IDLE.
- clk_blink  out  1  free-running square wave for the prompt blink.
- beat_cnt  out  7  current beat, 0..LAST_BEAT.
- star_cnt  out  2  sections passed so far, 0..3.
- beat_tick  out  1  one-cycle pulse on each beat advance.
- score  out  10  hit count, saturating at 999.

Behaviour:
- One clock domain. Reset is asynchronous and active-high; every register clears immediately on rst.
- Reset values: stop=1, level=0, clk_blink=0, beat_cnt=0, star_cnt=0, beat_tick=0, score=0, FSM=IDLE. All prescalers and tallies also clear.
- Blink: a counter runs 0..BLINK_DIV-1 in all states; clk_blink toggles when it wraps. The first toggle comes BLINK_DIV cycles after reset release.
- FSM states IDLE, PLAY, DONE. All outputs are registered.
- IDLE:
  - stop=1, level=0, beat_cnt=0.
  - start with level_sel!=0: next cycle go to PLAY, level<=level_sel, star_cnt/score/miss tally/beat prescaler <=0.
  - start with level_sel==0 is ignored.
- PLAY:
  - stop=0.
  - Beat prescaler counts 0..BEAT_DIV-1. On wrap, beat_tick=1 for exactly one cycle and beat_cnt increments in that same cycle.
  - hit: score+1, saturating at 999.
  - miss: section miss tally +1, 4 bits, saturating at 15.
  - hit and miss in the same cycle: both are counted.
  - start is ignored.
- Section end happens on the tick that moves beat_cnt 31->32, 63->64, or (LAST_BEAT-1)->LAST_BEAT. On that tick:
  - If the tally including any miss in the same cycle is < MISS_LIMIT, star_cnt+1, saturating at 3.
  - The tally is cleared.
- Tick reaching LAST_BEAT: go to DONE in the same cycle. beat_cnt holds LAST_BEAT, level is held, star_cnt is frozen.
- DONE:
  - stop=1. hit/miss are ignored.
  - start goes to IDLE, which clears level and beat_cnt and sets star_cnt to 0 on entry. A further start is needed to play again.
- rst asserted mid-PLAY aborts to IDLE with all reset values; no star is awarded for a partial section.
- beat_cnt never exceeds LAST_BEAT and never wraps.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE/PLAY/DONE, 2-bit encoding).
  - Section boundary constants 32 and 64.
  - SCORE_MAX=999.
- One sub-module, clk_divider_tick (parameter DIV; outputs a one-cycle tick and enable-gated clear), instantiated twice:
  - blink timebase, always enabled;
  - beat timebase, enabled only in PLAY, cleared on game start.

Test Plan:
- Use BEAT_DIV=4, BLINK_DIV=8 for all scenarios.
- Reset/blink: release rst -> stop=1, level=0, beat_cnt=0; clk_blink rises at cycle 8, falls at cycle 16.
- Start gating: start with level_sel=0 -> stays IDLE. Then start with level_sel=2 -> next cycle stop=0, level=2; beat_tick every 4 cycles; beat_cnt=1 after 4 cycles.
- Perfect run: no misses, 95 beats -> star_cnt becomes 1 at beat 32, 2 at 64, 3 at 95; stop=1; beat_cnt holds 95 in DONE.
- Miss threshold: 3 misses in section 1, 4 in section 2, 0 in section 3 -> star_cnt=1 at 32, still 1 at 64, 2 at 95. A miss coincident with the 63->64 tick counts in section 2.
- Score saturation: 1005 hit pulses during PLAY -> score=999. A simultaneous hit+miss increments both counts.
- Abort/restart: rst at beat 40 -> all reset values, IDLE. In DONE, start -> IDLE with level=0 and star_cnt=0.

Source files
------------

// File: rtl/game_progress_pkg.sv
// Shared definitions for the game-progress controller.
// Holds the game state encoding, the fixed section boundaries, the score
// ceiling and a helper that recognises a section-ending beat.
package game_progress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The first two sections end on fixed beats; the last one ends on LAST_BEAT.
    localparam logic [6:0] SECTION1_END = 7'd32;
    localparam logic [6:0] SECTION2_END = 7'd64;

    localparam logic [9:0] SCORE_MAX = 10'd999;
    localparam logic [3:0] TALLY_MAX = 4'd15;
    localparam logic [1:0] STAR_MAX  = 2'd3;

    // True when advancing to next_beat closes a section.
    function automatic logic is_section_end(input logic [6:0] next_beat,
                                            input logic [6:0] last_beat);
        return (next_beat == SECTION1_END) ||
               (next_beat == SECTION2_END) ||
               (next_beat == last_beat);
    endfunction

endpackage

// File: rtl/game_progress_if.sv
// Status/control bundle between the note judge, the game-progress
// controller and the VGA overlay.
//   start, level_sel, hit, miss : requests/pulses into the controller
//   stop, level, clk_blink, beat_cnt, star_cnt, beat_tick, score :
//                                 registered status out of the controller
// master = the side driving requests (judge/keys), slave = the controller.
interface game_progress_if;

    logic       start;
    logic [1:0] level_sel;
    logic       hit;
    logic       miss;

    logic       stop;
    logic [1:0] level;
    logic       clk_blink;
    logic [6:0] beat_cnt;
    logic [1:0] star_cnt;
    logic       beat_tick;
    logic [9:0] score;

    modport master (
        output start, level_sel, hit, miss,
        input  stop, level, clk_blink, beat_cnt, star_cnt, beat_tick, score
    );

    modport slave (
        input  start, level_sel, hit, miss,
        output stop, level, clk_blink, beat_cnt, star_cnt, beat_tick, score
    );

endinterface

// File: rtl/game_progress_clk_divider_tick.sv
// Programmable timebase: counts 0..DIV-1 while enabled and flags the wrap.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; tick can only assert while enabled
//   clr      : synchronous return to zero, wins over en
//   tick     : high during the cycle in which the counter wraps
module clk_divider_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Wrap indicator; the consumer registers it, so outputs stay registered.
    assign tick = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_progress.sv
// Game-progress controller for the VGA overlay.
// Converts start/level_sel and judged hit/miss pulses into overlay status:
// run state (stop), latched level, prompt blink, beat position, stars and
// score. Three sections (ending at beats 32, 64, LAST_BEAT) each earn a star
// when their miss tally stays below MISS_LIMIT.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : game_progress_if slave port (see interface for signal list)
module game_progress
    import game_progress_pkg::*;
#(
    parameter int BEAT_DIV   = 25_000_000,
    parameter int BLINK_DIV  = 50_000_000,
    parameter int MISS_LIMIT = 4,
    parameter int LAST_BEAT  = 95
) (
    input  logic            clk,
    input  logic            rst,
    game_progress_if.slave  bus
);

    localparam logic [6:0] LAST_BEAT_L  = 7'(LAST_BEAT);
    localparam logic [3:0] MISS_LIMIT_L = 4'(MISS_LIMIT);

    state_t     state;
    logic       stop_q;
    logic [1:0] level_q;
    logic       blink_q;
    logic [6:0] beat_q;
    logic [1:0] star_q;
    logic       tick_q;
    logic [9:0] score_q;
    logic [3:0] miss_tally;

    logic       blink_wrap;
    logic       beat_wrap;
    logic       start_ok;
    logic [3:0] tally_next;
    logic [6:0] beat_next;
    logic       section_end;

    assign start_ok = (state == ST_IDLE) && bus.start && (bus.level_sel != 2'd0);

    clk_divider_tick #(.DIV(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .clr  (1'b0),
        .tick (blink_wrap)
    );

    // Beat phase restarts on every game start so beat 1 lands BEAT_DIV
    // cycles after entering PLAY.
    clk_divider_tick #(.DIV(BEAT_DIV)) u_beat_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_PLAY),
        .clr  (start_ok),
        .tick (beat_wrap)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tally_next = miss_tally;
        if (bus.miss && (miss_tally != TALLY_MAX)) tally_next = miss_tally + 4'd1;
        beat_next   = beat_q + 7'd1;
        section_end = is_section_end(beat_next, LAST_BEAT_L);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) blink_q <= 1'b0;
        else if (blink_wrap) blink_q <= ~blink_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            stop_q     <= 1'b1;
            level_q    <= 2'd0;
            beat_q     <= 7'd0;
            star_q     <= 2'd0;
            tick_q     <= 1'b0;
            score_q    <= 10'd0;
            miss_tally <= 4'd0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    stop_q  <= 1'b1;
                    level_q <= 2'd0;
                    beat_q  <= 7'd0;
                    if (start_ok) begin
                        state      <= ST_PLAY;
                        stop_q     <= 1'b0;
                        level_q    <= bus.level_sel;
                        star_q     <= 2'd0;
                        score_q    <= 10'd0;
                        miss_tally <= 4'd0;
                    end
                end
                ST_PLAY: begin
                    if (bus.hit && (score_q != SCORE_MAX)) score_q <= score_q + 10'd1;
                    miss_tally <= tally_next;
                    if (beat_wrap) begin
                        tick_q <= 1'b1;
                        beat_q <= beat_next;
                        // A miss landing on the closing tick still belongs
                        // to the section being closed.
                        if (section_end) begin
                            if ((tally_next < MISS_LIMIT_L) && (star_q != STAR_MAX))
                                star_q <= star_q + 2'd1;
                            miss_tally <= 4'd0;
                        end
                        if (beat_next == LAST_BEAT_L) begin
                            state  <= ST_DONE;
                            stop_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        state   <= ST_IDLE;
                        level_q <= 2'd0;
                        beat_q  <= 7'd0;
                        star_q  <= 2'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stop      = stop_q;
    assign bus.level     = level_q;
    assign bus.clk_blink = blink_q;
    assign bus.beat_cnt  = beat_q;
    assign bus.star_cnt  = star_q;
    assign bus.beat_tick = tick_q;
    assign bus.score     = score_q;

endmodule

// File: tb/tb_game_progress.sv
module tb_game_progress;

    localparam int BEAT_DIV     = 4;
    localparam int BLINK_DIV    = 8;
    localparam int MISS_LIMIT   = 4;
    localparam int LAST_BEAT    = 95;
    localparam int GAME_CYCLES  = BEAT_DIV * LAST_BEAT;
    localparam int DONE_EXTRA   = 8;
    localparam int MAXP         = GAME_CYCLES + DONE_EXTRA;
    // Longer beat on the second instance so one game outlasts 1005 hits.
    localparam int SAT_BEAT_DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    game_progress_if bus();
    game_progress_if sat_bus();

    game_progress #(
        .BEAT_DIV(BEAT_DIV), .BLINK_DIV(BLINK_DIV),
        .MISS_LIMIT(MISS_LIMIT), .LAST_BEAT(LAST_BEAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    game_progress #(
        .BEAT_DIV(SAT_BEAT_DIV), .BLINK_DIV(BLINK_DIV),
        .MISS_LIMIT(MISS_LIMIT), .LAST_BEAT(LAST_BEAT)
    ) dut_sat (
        .clk(clk), .rst(rst), .bus(sat_bus)
    );

    // Per-cycle stimulus plan for one game, indexed by clock edge after start.
    bit       hit_plan   [0:MAXP];
    bit       miss_plan  [0:MAXP];
    bit       start_plan [0:MAXP];
    bit [1:0] sel_plan   [0:MAXP];

    function automatic int section_of(input int beat);
        return (beat < 32) ? 0 : ((beat < 64) ? 1 : 2);
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.level_sel = 2'd0; bus.hit = 1'b0; bus.miss = 1'b0;
        sat_bus.start = 1'b0; sat_bus.level_sel = 2'd0; sat_bus.hit = 1'b0; sat_bus.miss = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic make_plan(input int hit_pct, input int miss_pct);
        for (int p = 0; p <= MAXP; p++) begin
            if (p <= GAME_CYCLES) begin
                hit_plan[p]   = ($urandom_range(0, 99) < hit_pct);
                miss_plan[p]  = ($urandom_range(0, 99) < miss_pct);
                start_plan[p] = (p < GAME_CYCLES) && ($urandom_range(0, 19) == 0);
            end else begin
                hit_plan[p]   = $urandom_range(0, 1) == 1;
                miss_plan[p]  = $urandom_range(0, 1) == 1;
                start_plan[p] = 1'b0;
            end
            sel_plan[p] = 2'($urandom_range(0, 3));
        end
        hit_plan[0] = 1'b0; miss_plan[0] = 1'b0; start_plan[0] = 1'b0;
    endtask

    task automatic place_misses(input int lo, input int hi, input int n);
        int placed = 0;
        while (placed < n) begin
            int p;
            p = $urandom_range(lo, hi);
            if (!miss_plan[p]) begin
                miss_plan[p] = 1'b1;
                placed++;
            end
        end
    endtask

    // Plays one full game from IDLE through DONE plus a few DONE cycles,
    // checking every cycle against a count-based model.
    task automatic run_game(input logic [1:0] lvl, input string name);
        int hits = 0;
        int sec_miss [3] = '{0, 0, 0};
        int exp_beat, exp_star, exp_score;
        bit exp_tick, exp_stop;

        bus.start = 1'b1; bus.level_sel = lvl;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.stop !== 1'b0 || bus.level !== lvl || bus.score !== 10'd0 ||
            bus.star_cnt !== 2'd0 || bus.beat_cnt !== 7'd0) begin
            errors++;
            $display("FAIL %s_start stop=%b level=%0d score=%0d star=%0d beat=%0d want stop=0 level=%0d score=0 star=0 beat=0",
                     name, bus.stop, bus.level, bus.score, bus.star_cnt, bus.beat_cnt, lvl);
        end

        for (int p = 1; p <= MAXP; p++) begin
            bus.hit = hit_plan[p]; bus.miss = miss_plan[p];
            bus.start = start_plan[p]; bus.level_sel = sel_plan[p];
            @(negedge clk);
            idle_inputs();

            if (p <= GAME_CYCLES) begin
                if (hit_plan[p]) hits++;
                if (miss_plan[p]) sec_miss[section_of((p - 1) / BEAT_DIV)]++;
            end
            exp_beat  = (p / BEAT_DIV > LAST_BEAT) ? LAST_BEAT : p / BEAT_DIV;
            exp_tick  = (p <= GAME_CYCLES) && (p % BEAT_DIV == 0);
            exp_stop  = (p >= GAME_CYCLES);
            exp_score = (hits > 999) ? 999 : hits;
            exp_star  = 0;
            if (exp_beat >= 32 && sec_miss[0] < MISS_LIMIT) exp_star++;
            if (exp_beat >= 64 && sec_miss[1] < MISS_LIMIT) exp_star++;
            if (exp_beat >= LAST_BEAT && sec_miss[2] < MISS_LIMIT) exp_star++;

            checks++;
            if (bus.beat_cnt !== 7'(exp_beat)) begin
                errors++;
                $display("FAIL %s_beat_cnt p=%0d got %0d want %0d", name, p, bus.beat_cnt, exp_beat);
            end
            checks++;
            if (bus.beat_tick !== exp_tick) begin
                errors++;
                $display("FAIL %s_beat_tick p=%0d got %b want %b", name, p, bus.beat_tick, exp_tick);
            end
            checks++;
            if (bus.star_cnt !== 2'(exp_star)) begin
                errors++;
                $display("FAIL %s_star_cnt p=%0d got %0d want %0d", name, p, bus.star_cnt, exp_star);
            end
            checks++;
            if (bus.score !== 10'(exp_score)) begin
                errors++;
                $display("FAIL %s_score p=%0d got %0d want %0d", name, p, bus.score, exp_score);
            end
            checks++;
            if (bus.stop !== exp_stop || bus.level !== lvl) begin
                errors++;
                $display("FAIL %s_stop_level p=%0d got stop=%b level=%0d want stop=%b level=%0d",
                         name, p, bus.stop, bus.level, exp_stop, lvl);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.stop !== 1'b1 || bus.level !== 2'd0 || bus.clk_blink !== 1'b0 ||
            bus.beat_cnt !== 7'd0 || bus.star_cnt !== 2'd0 || bus.beat_tick !== 1'b0 ||
            bus.score !== 10'd0) begin
            errors++;
            $display("FAIL reset_values stop=%b level=%0d blink=%b beat=%0d star=%0d tick=%b score=%0d want 1/0/0/0/0/0/0",
                     bus.stop, bus.level, bus.clk_blink, bus.beat_cnt, bus.star_cnt, bus.beat_tick, bus.score);
        end
        for (int k = 1; k <= 2 * BLINK_DIV; k++) begin
            bit exp_blink;
            @(negedge clk);
            exp_blink = (k >= BLINK_DIV) && (k < 2 * BLINK_DIV);
            checks++;
            if (bus.clk_blink !== exp_blink || bus.stop !== 1'b1) begin
                errors++;
                $display("FAIL blink cycle=%0d got blink=%b stop=%b want blink=%b stop=1",
                         k, bus.clk_blink, bus.stop, exp_blink);
            end
        end
    endtask

    task automatic test_start_gating();
        apply_reset();
        bus.start = 1'b1; bus.level_sel = 2'd0;
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.stop !== 1'b1 || bus.level !== 2'd0 || bus.beat_cnt !== 7'd0) begin
                errors++;
                $display("FAIL gate_level0 cycle=%0d got stop=%b level=%0d beat=%0d want 1/0/0",
                         k, bus.stop, bus.level, bus.beat_cnt);
            end
            @(negedge clk);
        end
        bus.start = 1'b1; bus.level_sel = 2'd2;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.stop !== 1'b0 || bus.level !== 2'd2 || bus.beat_cnt !== 7'd0 || bus.beat_tick !== 1'b0) begin
            errors++;
            $display("FAIL gate_start got stop=%b level=%0d beat=%0d tick=%b want 0/2/0/0",
                     bus.stop, bus.level, bus.beat_cnt, bus.beat_tick);
        end
        for (int k = 1; k <= 3 * BEAT_DIV; k++) begin
            @(negedge clk);
            checks++;
            if (bus.beat_tick !== (k % BEAT_DIV == 0) || bus.beat_cnt !== 7'(k / BEAT_DIV)) begin
                errors++;
                $display("FAIL gate_beat cycle=%0d got tick=%b beat=%0d want tick=%b beat=%0d",
                         k, bus.beat_tick, bus.beat_cnt, (k % BEAT_DIV == 0), k / BEAT_DIV);
            end
        end
    endtask

    task automatic test_perfect_run();
        apply_reset();
        make_plan(40, 0);
        run_game(2'd1, "perfect");
        checks++;
        if (bus.star_cnt !== 2'd3 || bus.beat_cnt !== 7'(LAST_BEAT) || bus.stop !== 1'b1) begin
            errors++;
            $display("FAIL perfect_end got star=%0d beat=%0d stop=%b want 3/%0d/1",
                     bus.star_cnt, bus.beat_cnt, bus.stop, LAST_BEAT);
        end
    endtask

    // Continues from DONE: start returns to IDLE, a second start plays again.
    task automatic test_done_restart();
        bus.start = 1'b1; bus.level_sel = 2'd3;
        @(negedge clk);
        idle_inputs();
        repeat (2) begin
            checks++;
            if (bus.stop !== 1'b1 || bus.level !== 2'd0 || bus.star_cnt !== 2'd0 || bus.beat_cnt !== 7'd0) begin
                errors++;
                $display("FAIL done_to_idle got stop=%b level=%0d star=%0d beat=%0d want 1/0/0/0",
                         bus.stop, bus.level, bus.star_cnt, bus.beat_cnt);
            end
            @(negedge clk);
        end
        bus.start = 1'b1; bus.level_sel = 2'd3;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.stop !== 1'b0 || bus.level !== 2'd3) begin
            errors++;
            $display("FAIL done_replay got stop=%b level=%0d want 0/3", bus.stop, bus.level);
        end
    endtask

    task automatic test_miss_threshold();
        apply_reset();
        make_plan(50, 0);
        place_misses(1, 32 * BEAT_DIV, 3);
        place_misses(32 * BEAT_DIV + 1, 64 * BEAT_DIV - 1, 3);
        miss_plan[64 * BEAT_DIV] = 1'b1;
        hit_plan[64 * BEAT_DIV]  = 1'b1;
        run_game(2'd3, "threshold");
        checks++;
        if (bus.star_cnt !== 2'd2) begin
            errors++;
            $display("FAIL threshold_end got star=%0d want 2", bus.star_cnt);
        end
    endtask

    task automatic test_random_games();
        apply_reset();
        for (int g = 0; g < 2; g++) begin
            make_plan($urandom_range(10, 90), $urandom_range(0, 8));
            run_game(2'($urandom_range(1, 3)), "random");
            bus.start = 1'b1; bus.level_sel = 2'd0;
            @(negedge clk);
            idle_inputs();
            checks++;
            if (bus.stop !== 1'b1 || bus.level !== 2'd0 || bus.star_cnt !== 2'd0) begin
                errors++;
                $display("FAIL random_back_to_idle game=%0d got stop=%b level=%0d star=%0d want 1/0/0",
                         g, bus.stop, bus.level, bus.star_cnt);
            end
        end
    endtask

    task automatic test_score_saturation();
        apply_reset();
        sat_bus.start = 1'b1; sat_bus.level_sel = 2'd1;
        @(negedge clk);
        idle_inputs();
        for (int n = 1; n <= 1005; n++) begin
            sat_bus.hit  = 1'b1;
            sat_bus.miss = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            idle_inputs();
            checks++;
            if (sat_bus.score !== 10'((n > 999) ? 999 : n)) begin
                errors++;
                $display("FAIL score_sat n=%0d got %0d want %0d", n, sat_bus.score, (n > 999) ? 999 : n);
            end
        end
        checks++;
        if (sat_bus.stop !== 1'b0) begin
            errors++;
            $display("FAIL score_sat_playing got stop=%b want 0", sat_bus.stop);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        bus.start = 1'b1; bus.level_sel = 2'd2;
        @(negedge clk);
        idle_inputs();
        for (int p = 1; p <= 40 * BEAT_DIV; p++) begin
            bus.hit = $urandom_range(0, 1) == 1;
            @(negedge clk);
            idle_inputs();
        end
        checks++;
        if (bus.beat_cnt !== 7'd40 || bus.star_cnt !== 2'd1 || bus.stop !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre got beat=%0d star=%0d stop=%b want 40/1/0",
                     bus.beat_cnt, bus.star_cnt, bus.stop);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.stop !== 1'b1 || bus.level !== 2'd0 || bus.beat_cnt !== 7'd0 ||
            bus.star_cnt !== 2'd0 || bus.score !== 10'd0 || bus.beat_tick !== 1'b0) begin
            errors++;
            $display("FAIL abort_async got stop=%b level=%0d beat=%0d star=%0d score=%0d tick=%b want 1/0/0/0/0/0",
                     bus.stop, bus.level, bus.beat_cnt, bus.star_cnt, bus.score, bus.beat_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2 * BEAT_DIV; k++) begin
            @(negedge clk);
            checks++;
            if (bus.stop !== 1'b1 || bus.beat_cnt !== 7'd0 || bus.beat_tick !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle cycle=%0d got stop=%b beat=%0d tick=%b want 1/0/0",
                         k, bus.stop, bus.beat_cnt, bus.beat_tick);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_start_gating();
        test_perfect_run();
        test_done_restart();
        test_miss_threshold();
        test_random_games();
        test_score_saturation();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
